// File: rtl/seq_mult_ctrl_if.sv
// Bundle between the shift-add multiplier controller, the opcode decode,
// the result mux and the external 32-bit adder.
interface seq_mult_ctrl_if #(parameter int WIDTH = 32);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     add_a;
   logic [WIDTH-1:0]     add_b;
   logic                 add_cin;
   logic [WIDTH-1:0]     add_sum;
   logic                 add_cout;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   // master: decode/adder side; slave: the controller
   modport master (
      output start, multiplicand, multiplier, add_sum, add_cout,
      input  add_a, add_b, add_cin, busy, done, product
   );
   modport slave (
      input  start, multiplicand, multiplier, add_sum, add_cout,
      output add_a, add_b, add_cin, busy, done, product
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Iteration controller for an unsigned shift-add multiplier; one add per
// clock through an external adder, 32 iterations per product.
module seq_mult_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_mult_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_p_hi;
   logic [WIDTH-1:0]   r_p_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_run;
   logic               w_last;

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_last)    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Carry-out enters the MSB so M >= 2^31 cannot lose a bit on the shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m    <= '0;
         r_p_hi <= '0;
         r_p_lo <= '0;
         r_cnt  <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_m    <= bus.multiplicand;
         r_p_hi <= '0;
         r_p_lo <= bus.multiplier;
         r_cnt  <= '0;
      end else if (w_run) begin
         {r_p_hi, r_p_lo} <= {bus.add_cout, bus.add_sum, r_p_lo[WIDTH-1:1]};
         r_cnt            <= r_cnt + 1'b1;
      end
   end

   assign bus.add_a   = w_run ? r_p_hi : '0;
   assign bus.add_b   = (w_run && r_p_lo[0]) ? r_m : '0;
   assign bus.add_cin = 1'b0;
   assign bus.busy    = w_run;
   assign bus.done    = (r_state == S_DONE);
   assign bus.product = {r_p_hi, r_p_lo};

endmodule
